parking_entry_allocator: RTL and testbench

- Upstream stage of the parking capacity counter.
- Tracks which of the 8 spots are occupied, serves gate entry requests by allocating the lowest-index free spot, and retires spots on exit events.
- Drives the 8-bit occupancy bitmap `capacity`, which connects directly to the counter's `new_capacity` input.
- Also sequences the entry barrier: the gate stays open for a fixed number of cycles after each grant.

---
 rtl/parking_entry_allocator.sv | 84 ++++++++
 tb/tb_parking_entry_allocator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/parking_entry_allocator.sv
// parking_entry_allocator: allocates the lowest free of 8 parking spots on entry, retires spots on exit, sequences the entry gate
// Ports: clk/rst_n (async active-low); entry_req level request; exit_valid/exit_spot exit event;
//        entry_ack/entry_spot grant pulse; entry_reject lot-full pulse; exit_error exit-on-free-spot pulse;
//        gate_open barrier; capacity occupancy bitmap; full all spots occupied.
module parking_entry_allocator #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_valid,
  input  logic [2:0] exit_spot,
  output logic       entry_ack,
  output logic [2:0] entry_spot,
  output logic       entry_reject,
  output logic       exit_error,
  output logic       gate_open,
  output logic [7:0] capacity,
  output logic       full
);
  typedef enum logic [1:0] {IDLE, ALLOC, GATE} state_t;
  state_t     state_q;
  logic [7:0] capacity_q, cap_exit_d;
  logic [3:0] timer_q;
  logic       lock_q, ack_q, rej_q, err_q, gate_q;
  logic [2:0] spot_q, free_spot_d;
  always_comb begin
    cap_exit_d = (exit_valid && capacity_q[exit_spot]) ? capacity_q & ~(8'b1 << exit_spot) : capacity_q;
    free_spot_d = 3'd0;
    // search the post-exit bitmap, which is exactly what the register holds during ALLOC
    for (int i = 7; i >= 0; i--) if (!cap_exit_d[i]) free_spot_d = 3'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      capacity_q <= 8'h00;
      timer_q    <= 4'd0;
      lock_q     <= 1'b0;
      ack_q      <= 1'b0;
      rej_q      <= 1'b0;
      err_q      <= 1'b0;
      gate_q     <= 1'b0;
      spot_q     <= 3'd0;
    end else begin
      ack_q      <= 1'b0;
      rej_q      <= 1'b0;
      err_q      <= exit_valid && !capacity_q[exit_spot];
      capacity_q <= cap_exit_d;
      lock_q     <= lock_q && entry_req;
      case (state_q)
        IDLE: if (entry_req && !lock_q) begin
          if (&capacity_q) begin
            rej_q  <= 1'b1;
            lock_q <= 1'b1;
          end else begin
            state_q <= ALLOC;
            ack_q   <= 1'b1;
            spot_q  <= free_spot_d;
          end
        end
        ALLOC: begin
          // the granted bit is free, so a concurrent exit never touches it
          capacity_q <= cap_exit_d | (8'b1 << spot_q);
          timer_q    <= 4'(GATE_CYCLES);
          gate_q     <= 1'b1;
          state_q    <= GATE;
        end
        GATE: if (timer_q == 4'd1) begin
          state_q <= IDLE;
          gate_q  <= 1'b0;
          timer_q <= 4'd0;
        end else timer_q <= timer_q - 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign entry_ack    = ack_q;
  assign entry_spot   = spot_q;
  assign entry_reject = rej_q;
  assign exit_error   = err_q;
  assign gate_open    = gate_q;
  assign capacity     = capacity_q;
  assign full         = &capacity_q;
endmodule

// File: tb/tb_parking_entry_allocator.sv
// tb_parking_entry_allocator: directed and randomized checks of the parking entry allocator against a reference model
module tb_parking_entry_allocator;
  localparam int G = 4;
  logic       clk = 1'b0, rst_n = 1'b0, entry_req = 1'b0, exit_valid = 1'b0;
  logic [2:0] exit_spot = 3'd0;
  logic       entry_ack, entry_reject, exit_error, gate_open, full;
  logic [2:0] entry_spot;
  logic [7:0] capacity;
  int tests = 0, fails = 0;
  bit         occ [8];
  int         phase;
  bit         locked, e_ack, e_rej, e_err;
  logic [2:0] e_spot;
  parking_entry_allocator #(.GATE_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_valid(exit_valid), .exit_spot(exit_spot),
    .entry_ack(entry_ack), .entry_spot(entry_spot), .entry_reject(entry_reject), .exit_error(exit_error),
    .gate_open(gate_open), .capacity(capacity), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] occ_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = occ[i];
    return v;
  endfunction
  task automatic model_reset();
    foreach (occ[i]) occ[i] = 0;
    phase = 0; locked = 0; e_ack = 0; e_rej = 0; e_err = 0; e_spot = 3'd0;
  endtask
  // phase: 0 idle, 1 grant cycle, 2..G+1 gate open
  task automatic model_edge(input bit req, input bit ev, input logic [2:0] es);
    bit was_full, was_locked;
    int nph;
    was_full = (occ_vec() == 8'hFF);
    was_locked = locked;
    e_ack = 0; e_rej = 0;
    e_err = ev && !occ[es];
    if (ev && occ[es]) occ[es] = 0;
    if (phase == 1) occ[e_spot] = 1;
    nph = 0;
    if (phase == 0) begin
      if (req && !was_locked) begin
        if (was_full) e_rej = 1;
        else begin
          e_ack = 1;
          nph = 1;
          for (int i = 7; i >= 0; i--) if (!occ[i]) e_spot = 3'(i);
        end
      end
    end else nph = (phase == G + 1) ? 0 : phase + 1;
    locked = (was_locked && req) || e_rej;
    phase = nph;
  endtask
  task automatic check_all();
    chk("ack", {7'd0, entry_ack}, {7'd0, e_ack});
    chk("spot", {5'd0, entry_spot}, {5'd0, e_spot});
    chk("reject", {7'd0, entry_reject}, {7'd0, e_rej});
    chk("exit_err", {7'd0, exit_error}, {7'd0, e_err});
    chk("gate", {7'd0, gate_open}, {7'd0, 1'(phase >= 2)});
    chk("capacity", capacity, occ_vec());
    chk("full", {7'd0, full}, {7'd0, 1'(occ_vec() == 8'hFF)});
  endtask
  task automatic step(input bit req, input bit ev, input logic [2:0] es);
    entry_req = req; exit_valid = ev; exit_spot = es;
    @(posedge clk);
    model_edge(req, ev, es);
    #1;
    check_all();
  endtask
  task automatic request(input logic [2:0] exp_spot);
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1, 0, 3'd0);
      done = entry_ack || entry_reject;
    end
    chk("req_done", {7'd0, done}, 8'd1);
    chk("req_spot", {5'd0, entry_spot}, {5'd0, exp_spot});
    repeat (G + 1) step(0, 0, 3'd0);
  endtask
  initial begin
    int cnt, rcnt, acnt;
    bit rreq;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    step(1, 0, 3'd0);
    chk("first_ack", {7'd0, entry_ack}, 8'd1);
    chk("first_spot", {5'd0, entry_spot}, 8'd0);
    cnt = 0;
    for (int k = 0; k < G + 2; k++) begin
      step(0, 0, 3'd0);
      cnt += int'(gate_open);
    end
    chk("gate_len", 8'(cnt), 8'(G));
    chk("cap_01", capacity, 8'h01);
    for (int s = 1; s < 8; s++) request(3'(s));
    chk("cap_ff", capacity, 8'hFF);
    chk("full_1", {7'd0, full}, 8'd1);
    rcnt = 0; acnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 3'd0);
      rcnt += int'(entry_reject);
      acnt += int'(entry_ack);
    end
    chk("one_reject", 8'(rcnt), 8'd1);
    chk("no_ack_full", 8'(acnt), 8'd0);
    step(0, 0, 3'd0);
    step(0, 1, 3'd3);
    chk("cap_f7", capacity, 8'hF7);
    request(3'd3);
    chk("cap_ff_again", capacity, 8'hFF);
    step(0, 1, 3'd1); step(0, 1, 3'd3); step(0, 1, 3'd4);
    step(0, 1, 3'd5); step(0, 1, 3'd6); step(0, 1, 3'd7);
    chk("cap_05", capacity, 8'h05);
    step(0, 1, 3'd1);
    chk("err_pulse", {7'd0, exit_error}, 8'd1);
    chk("cap_05_kept", capacity, 8'h05);
    step(0, 0, 3'd0);
    chk("err_cleared", {7'd0, exit_error}, 8'd0);
    request(3'd1);
    step(0, 1, 3'd2);
    chk("cap_03", capacity, 8'h03);
    step(1, 0, 3'd0);
    chk("alloc2_spot", {5'd0, entry_spot}, 8'd2);
    step(0, 1, 3'd0);
    chk("cap_06", capacity, 8'h06);
    repeat (G) step(0, 0, 3'd0);
    request(3'd0); request(3'd3); request(3'd4); request(3'd5);
    step(1, 0, 3'd0);
    step(0, 0, 3'd0);
    step(0, 1, 3'd6);
    chk("cap_3f_gate", capacity, 8'h3F);
    chk("in_gate", {7'd0, gate_open}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    rreq = 0;
    for (int k = 0; k < 400; k++) begin
      if (!rreq) rreq = ($urandom_range(0, 2) == 0);
      step(rreq, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      if (e_ack || e_rej) rreq = 0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
